// File: rtl/btn_cntr_pkg.sv
// Shared types and defaults for the multi-channel button controller.
// Repeat generation is controlled by the BTN_CNTR_REPEAT_EN macro in btn_chan_fsm.
package btn_cntr_pkg;

  localparam int DEB_W            = 4;
  localparam int TICK_DIV_DEF     = 100_000;
  localparam int LONG_TICKS_DEF   = 700;
  localparam int REPEAT_TICKS_DEF = 100;

  // Legacy numeric encodings kept so existing decode logic still matches.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    PRESSED = ST_PRESSED,
    HELD    = ST_HELD
  } chan_state_t;

endpackage

// File: rtl/btn_chan_fsm.sv
// One button channel: 2-flop synchroniser, tick-sampled debounce, short/long/repeat FSM.
// Define BTN_CNTR_REPEAT_EN to enable repeat_pulse generation in the HELD state.
module btn_chan_fsm
  import btn_cntr_pkg::*;
#(
  parameter int DEB_CNT      = 3,
  parameter int LONG_TICKS   = LONG_TICKS_DEF,
  parameter int REPEAT_TICKS = REPEAT_TICKS_DEF,
  parameter int CNT_W        = 12
) (
  input  logic clk,
  input  logic reset_p,
  input  logic tick,
  input  logic btn,
  output logic btn_level,
  output logic press_pedge,
  output logic release_nedge,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse
);

  logic             sync1;
  logic             sync2;
  logic [DEB_W-1:0] deb_cnt;
  logic [DEB_W-1:0] deb_cnt_next;
  logic             level_next;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] hold_cnt;
  chan_state_t      state;

  always_comb begin
    level_next   = btn_level;
    deb_cnt_next = deb_cnt;
    if (tick) begin
      if (sync2 == btn_level) begin
        deb_cnt_next = '0;
      end else if (deb_cnt == DEB_W'(DEB_CNT - 1)) begin
        level_next   = ~btn_level;
        deb_cnt_next = '0;
      end else begin
        deb_cnt_next = deb_cnt + 1'b1;
      end
    end
  end

  assign rise = level_next & ~btn_level;
  assign fall = ~level_next & btn_level;

`ifdef BTN_CNTR_REPEAT_EN
  logic [CNT_W-1:0] rep_cnt;
`else
  assign repeat_pulse = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset_p) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      deb_cnt       <= '0;
      btn_level     <= 1'b0;
      press_pedge   <= 1'b0;
      release_nedge <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      hold_cnt      <= '0;
      state         <= IDLE;
`ifdef BTN_CNTR_REPEAT_EN
      rep_cnt       <= '0;
      repeat_pulse  <= 1'b0;
`endif
    end else begin
      sync1         <= btn;
      sync2         <= sync1;
      deb_cnt       <= deb_cnt_next;
      btn_level     <= level_next;
      press_pedge   <= rise;
      release_nedge <= fall;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
`ifdef BTN_CNTR_REPEAT_EN
      repeat_pulse  <= 1'b0;
`endif
      // A fall only happens on a tick, so checking it first makes release win
      // over the hold and repeat thresholds.
      case (state)
        IDLE: begin
          if (rise) begin
            state    <= PRESSED;
            hold_cnt <= '0;
          end
        end
        PRESSED: begin
          if (fall) begin
            state       <= IDLE;
            short_press <= 1'b1;
          end else if (tick) begin
            if (hold_cnt == CNT_W'(LONG_TICKS - 1)) begin
              state      <= HELD;
              long_press <= 1'b1;
`ifdef BTN_CNTR_REPEAT_EN
              rep_cnt    <= '0;
`endif
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        HELD: begin
          if (fall) begin
            state <= IDLE;
          end
`ifdef BTN_CNTR_REPEAT_EN
          else if (tick) begin
            if (rep_cnt == CNT_W'(REPEAT_TICKS - 1)) begin
              repeat_pulse <= 1'b1;
              rep_cnt      <= '0;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/btn_cntr_multi.sv
// N-channel debounce / short-long press / auto-repeat controller sharing one sample tick.
// Repeat pulses exist only when BTN_CNTR_REPEAT_EN is defined.
module btn_cntr_multi
  import btn_cntr_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int DEB_CNT      = 3,
  parameter int LONG_TICKS   = LONG_TICKS_DEF,
  parameter int REPEAT_TICKS = REPEAT_TICKS_DEF,
  parameter int CNT_W        = 12
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pedge,
  output logic [N_BTN-1:0] release_nedge,
  output logic [N_BTN-1:0] short_press,
  output logic [N_BTN-1:0] long_press,
  output logic [N_BTN-1:0] repeat_pulse
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset_p) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_chan_fsm #(
      .DEB_CNT      (DEB_CNT),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS),
      .CNT_W        (CNT_W)
    ) u_chan (
      .clk           (clk),
      .reset_p       (reset_p),
      .tick          (tick),
      .btn           (btn[i]),
      .btn_level     (btn_level[i]),
      .press_pedge   (press_pedge[i]),
      .release_nedge (release_nedge[i]),
      .short_press   (short_press[i]),
      .long_press    (long_press[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_btn_cntr_multi.sv
// Self-checking bench for btn_cntr_multi: directed scenarios plus random button activity
// checked every cycle against a behavioural model (honours BTN_CNTR_REPEAT_EN).
module tb_btn_cntr_multi;

  localparam int N  = 4;
  localparam int TD = 10;
  localparam int DC = 3;
  localparam int LT = 20;
  localparam int RT = 5;
  localparam int CW = 12;
`ifdef BTN_CNTR_REPEAT_EN
  localparam int REP_EXP = 4;
`else
  localparam int REP_EXP = 0;
`endif

  logic         clk = 1'b0;
  logic         reset_p;
  logic [N-1:0] btn;
  logic [N-1:0] btn_level, press_pedge, release_nedge, short_press, long_press, repeat_pulse;

  always #5 clk = ~clk;

  btn_cntr_multi #(
    .N_BTN        (N),
    .TICK_DIV     (TD),
    .DEB_CNT      (DC),
    .LONG_TICKS   (LT),
    .REPEAT_TICKS (RT),
    .CNT_W        (CW)
  ) dut (
    .clk           (clk),
    .reset_p       (reset_p),
    .btn           (btn),
    .btn_level     (btn_level),
    .press_pedge   (press_pedge),
    .release_nedge (release_nedge),
    .short_press   (short_press),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model: synchroniser delay line, run length of differing samples,
  // and a single "ticks since press" count from which long/repeat are derived.
  int  mt;
  bit  q1 [N];
  bit  q2 [N];
  bit  ml [N];
  int  run[N];
  bit  act[N];
  int  tsp[N];
  logic [N-1:0] e_level, e_press, e_rel, e_short, e_long, e_rep;

  int n_press[N], n_rel[N], n_short[N], n_long[N], n_rep[N], n_rs[N];

  task automatic model_edge();
    bit tk;
    bit was, now;
    tk      = (mt == TD - 1);
    e_press = '0;
    e_rel   = '0;
    e_short = '0;
    e_long  = '0;
    e_rep   = '0;
    if (reset_p) begin
      mt      = 0;
      e_level = '0;
      for (int c = 0; c < N; c++) begin
        q1[c] = 0; q2[c] = 0; ml[c] = 0; run[c] = 0; act[c] = 0; tsp[c] = 0;
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        was = ml[c];
        now = was;
        if (tk) begin
          if (q2[c] != ml[c]) begin
            run[c]++;
            if (run[c] == DC) begin
              now    = ~was;
              run[c] = 0;
            end
          end else begin
            run[c] = 0;
          end
        end
        ml[c]      = now;
        e_level[c] = now;
        e_press[c] = now & ~was;
        e_rel[c]   = was & ~now;
        if (e_press[c]) begin
          act[c] = 1;
          tsp[c] = 0;
        end else if (act[c] && e_rel[c]) begin
          e_short[c] = (tsp[c] < LT);
          act[c]     = 0;
        end else if (act[c] && tk) begin
          tsp[c]++;
          e_long[c] = (tsp[c] == LT);
`ifdef BTN_CNTR_REPEAT_EN
          e_rep[c] = (tsp[c] > LT) && (((tsp[c] - LT) % RT) == 0);
`endif
        end
        q2[c] = q1[c];
        q1[c] = btn[c];
      end
      mt = tk ? 0 : mt + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < N; c++) begin
      n_press[c] = 0; n_rel[c] = 0; n_short[c] = 0; n_long[c] = 0; n_rep[c] = 0; n_rs[c] = 0;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("btn_level", btn_level, e_level);
    chk("press_pedge", press_pedge, e_press);
    chk("release_nedge", release_nedge, e_rel);
    chk("short_press", short_press, e_short);
    chk("long_press", long_press, e_long);
    chk("repeat_pulse", repeat_pulse, e_rep);
    for (int c = 0; c < N; c++) begin
      n_press[c] += int'(press_pedge[c] === 1'b1);
      n_rel[c]   += int'(release_nedge[c] === 1'b1);
      n_short[c] += int'(short_press[c] === 1'b1);
      n_long[c]  += int'(long_press[c] === 1'b1);
      n_rep[c]   += int'(repeat_pulse[c] === 1'b1);
      n_rs[c]    += int'((release_nedge[c] & short_press[c]) === 1'b1);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until the model's hold count for channel c reaches target; bounded.
  task automatic wait_tsp(input int c, input int target, input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step();
      found = act[c] && (tsp[c] >= target);
    end
    checks++;
    assert (found) else begin
      failures++;
      $error("FAIL %s observed=timeout expected=hold_ticks>=%0d", tag, target);
    end
  endtask

  initial begin
    int dur;
    btn     = '1;
    reset_p = 1'b1;
    clear_counts();

    // 1. buttons held through reset
    steps(5);
    chk("reset_outputs", btn_level | press_pedge | release_nedge | long_press, '0);
    reset_p = 1'b0;
    step();
    chk("post_reset_pulses", press_pedge | release_nedge | short_press | long_press | repeat_pulse, '0);
    steps(60);
    chk("level_after_reset_hold", btn_level, 4'b1111);
    chk_int("press_after_reset_hold", n_press[0] + n_press[1] + n_press[2] + n_press[3], 4);
    btn = '0;
    steps(60);
    chk("level_released", btn_level, 4'b0000);

    // 2. bounce on ch0
    clear_counts();
    for (int i = 0; i < 100; i++) begin
      if (i % 7 == 0) btn[0] = ~btn[0];
      step();
    end
    chk_int("bounce_no_press", n_press[0], 0);
    btn[0] = 1'b1;
    steps(50);
    chk_int("bounce_one_press", n_press[0], 1);
    btn[0] = 1'b0;
    steps(50);

    // 3. short press on ch1
    clear_counts();
    btn[1] = 1'b1;
    steps(100);
    btn[1] = 1'b0;
    steps(60);
    chk_int("short_press_cnt", n_press[1], 1);
    chk_int("short_release_cnt", n_rel[1], 1);
    chk_int("short_same_cycle", n_rs[1], 1);
    chk_int("short_no_long", n_long[1], 0);

    // 4. long press with repeats on ch2
    clear_counts();
    btn[2] = 1'b1;
    steps(420);
    btn[2] = 1'b0;
    steps(60);
    chk_int("long_cnt", n_long[2], 1);
    chk_int("repeat_cnt", n_rep[2], REP_EXP);
    chk_int("long_no_short", n_short[2], 0);
    chk_int("long_release_cnt", n_rel[2], 1);

    // 5. release lands exactly on the threshold tick, then one tick later
    clear_counts();
    btn[3] = 1'b1;
    wait_tsp(3, 17, "boundary_wait_a");
    btn[3] = 1'b0;
    steps(60);
    chk_int("boundary_short", n_short[3], 1);
    chk_int("boundary_no_long", n_long[3], 0);
    clear_counts();
    btn[3] = 1'b1;
    wait_tsp(3, 18, "boundary_wait_b");
    btn[3] = 1'b0;
    steps(60);
    chk_int("past_boundary_long", n_long[3], 1);
    chk_int("past_boundary_no_short", n_short[3], 0);

    // 6. overlapping ch0 short / ch1 long, reset while ch1 is HELD
    clear_counts();
    btn[0] = 1'b1;
    btn[1] = 1'b1;
    steps(80);
    btn[0] = 1'b0;
    wait_tsp(1, LT + 2, "held_wait");
    chk_int("overlap_ch0_short", n_short[0], 1);
    chk_int("overlap_ch1_long", n_long[1], 1);
    reset_p = 1'b1;
    steps(3);
    reset_p = 1'b0;
    clear_counts();
    steps(25);
    chk_int("ch1_silent_after_reset", n_press[1] + n_rel[1] + n_short[1] + n_long[1] + n_rep[1], 0);
    steps(40);
    chk_int("ch1_fresh_press", n_press[1], 1);
    btn[1] = 1'b0;
    steps(60);

    // Random activity on all channels, occasional reset
    for (int b = 0; b < 40; b++) begin
      btn = N'($urandom);
      dur = (($urandom_range(0, 3) == 0) ? $urandom_range(1, 25) : $urandom_range(20, 300));
      if ($urandom_range(0, 9) == 0) begin
        reset_p = 1'b1;
        steps($urandom_range(1, 4));
        reset_p = 1'b0;
      end
      steps(dur);
    end
    btn = '0;
    steps(80);
    chk("final_idle_level", btn_level, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
